// File: rtl/instr_loader_pkg.sv
// instr_loader_pkg: definitions shared by the program loader, decode and
// debug units.
//   state_t    - loader FSM state encoding (3 bits).
//   HALT_INSTR - end-of-program marker word.
package instr_loader_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_BYTE = 3'd1,
    WRITE     = 3'd2,
    DONE      = 3'd3,
    ERROR     = 3'd4
  } state_t;

  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

endpackage

// File: rtl/instr_loader_if.sv
// instr_loader_if: groups the loader's control, UART byte input and
// instruction-memory write port.
//   i_start       - one-cycle load/restart request
//   i_rx_data     - byte from the UART receiver
//   i_rx_done     - one-cycle strobe, i_rx_data valid
//   o_write_en    - instruction-memory write enable
//   o_instrmem_en - instruction-memory enable
//   o_write_data  - byte to write (MEM_SIZE bits)
//   o_write_addr  - byte address to write (INSTMEM_SIZE bits)
//   o_pc_reset    - holds the fetch-stage PC in reset
//   o_loading     - load in progress
//   o_done        - HALT received, program loaded
//   o_overflow    - memory filled without HALT
// Modports: master = loader, slave = surrounding fetch/UART logic.
interface instr_loader_if #(
  parameter int MEM_SIZE     = 8,
  parameter int INSTMEM_SIZE = 8
);
  logic                    i_start;
  logic [7:0]              i_rx_data;
  logic                    i_rx_done;
  logic                    o_write_en;
  logic                    o_instrmem_en;
  logic [MEM_SIZE-1:0]     o_write_data;
  logic [INSTMEM_SIZE-1:0] o_write_addr;
  logic                    o_pc_reset;
  logic                    o_loading;
  logic                    o_done;
  logic                    o_overflow;

  modport master (
    input  i_start, i_rx_data, i_rx_done,
    output o_write_en, o_instrmem_en, o_write_data, o_write_addr,
           o_pc_reset, o_loading, o_done, o_overflow
  );

  modport slave (
    output i_start, i_rx_data, i_rx_done,
    input  o_write_en, o_instrmem_en, o_write_data, o_write_addr,
           o_pc_reset, o_loading, o_done, o_overflow
  );
endinterface

// File: rtl/instr_loader_word_assembler.sv
// instr_loader_word_assembler: word_assembler sub-module. Shifts bytes into
// a BYTES-wide word, first byte ending up as the MSB (big-endian), and keeps
// a byte index that wraps modulo BYTES.
//   clk, rst      - clock, synchronous active-high reset
//   clear         - zero the word and the byte index
//   shift         - shift byte_in into the LSB end of the word
//   advance       - step the byte index
//   byte_in       - incoming byte
//   word          - assembled word
//   word_complete - byte index is at the last byte of a word
module instr_loader_word_assembler #(
  parameter int BYTES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 shift,
  input  logic                 advance,
  input  logic [7:0]           byte_in,
  output logic [8*BYTES-1:0]   word,
  output logic                 word_complete
);
  localparam int IW = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [IW-1:0] index;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      word  <= '0;
      index <= '0;
    end else begin
      if (shift)
        word <= {word[8*BYTES-9:0], byte_in};
      if (advance)
        index <= (index == IW'(BYTES-1)) ? '0 : index + 1'b1;
    end
  end

  assign word_complete = (index == IW'(BYTES-1));
endmodule

// File: rtl/instr_loader.sv
// instr_loader: program-loading stage upstream of instruction fetch.
// Writes the UART byte stream into instruction memory one byte per write,
// holding the PC in reset until an aligned HALT word is stored, then
// releases the PC. Filling memory without HALT ends in ERROR.
//   i_clock, i_reset - clock, synchronous active-high reset
//   bus              - instr_loader_if.master (start, UART input, memory
//                      write port and status flags)
module instr_loader #(
  parameter int MEM_SIZE     = 8,
  parameter int INSTMEM_SIZE = 8,
  parameter int INST_SIZE    = 32,
  parameter logic [INST_SIZE-1:0] HALT_INSTR = INST_SIZE'(instr_loader_pkg::HALT_INSTR)
) (
  input  logic            i_clock,
  input  logic            i_reset,
  instr_loader_if.master  bus
);
  import instr_loader_pkg::*;

  state_t                  state;
  logic [INSTMEM_SIZE-1:0] addr_cnt;
  logic [INST_SIZE-1:0]    word;
  logic                    word_complete;
  logic                    start_ok;
  logic                    byte_in;

  assign start_ok = bus.i_start && (state == IDLE || state == DONE || state == ERROR);
  assign byte_in  = (state == WAIT_BYTE) && bus.i_rx_done;

  instr_loader_word_assembler #(
    .BYTES(INST_SIZE / 8)
  ) u_word_assembler (
    .clk          (i_clock),
    .rst          (i_reset),
    .clear        (start_ok),
    .shift        (byte_in),
    .advance      (state == WRITE),
    .byte_in      (bus.i_rx_data),
    .word         (word),
    .word_complete(word_complete)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state             <= IDLE;
      addr_cnt          <= '0;
      bus.o_write_data  <= '0;
      bus.o_write_addr  <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (bus.i_start) begin
            state    <= WAIT_BYTE;
            addr_cnt <= '0;
          end
        end
        WAIT_BYTE: begin
          if (bus.i_rx_done) begin
            bus.o_write_data <= MEM_SIZE'(bus.i_rx_data);
            bus.o_write_addr <= addr_cnt;
            state            <= WRITE;
          end
        end
        WRITE: begin
          addr_cnt <= addr_cnt + 1'b1;
          // HALT wins over the top-address check so a program whose HALT
          // lands in the last word still completes.
          if (word_complete && word == HALT_INSTR)
            state <= DONE;
          else if (addr_cnt == '1)
            state <= ERROR;
          else
            state <= WAIT_BYTE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status and memory strobes are decoded from the state register only.
  assign bus.o_write_en    = (state == WRITE);
  assign bus.o_instrmem_en = (state == WRITE) || (state == DONE);
  assign bus.o_pc_reset    = (state != DONE);
  assign bus.o_loading     = (state == WAIT_BYTE) || (state == WRITE);
  assign bus.o_done        = (state == DONE);
  assign bus.o_overflow    = (state == ERROR);
endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int wr8 = 0;
  int wr4 = 0;

  always #5 clk = ~clk;

  instr_loader_if #(.MEM_SIZE(8), .INSTMEM_SIZE(8)) bus8 ();
  instr_loader_if #(.MEM_SIZE(8), .INSTMEM_SIZE(4)) bus4 ();

  assign bus8.i_start   = start;
  assign bus8.i_rx_data = rx_data;
  assign bus8.i_rx_done = rx_done;
  assign bus4.i_start   = start;
  assign bus4.i_rx_data = rx_data;
  assign bus4.i_rx_done = rx_done;

  instr_loader #(.MEM_SIZE(8), .INSTMEM_SIZE(8), .INST_SIZE(32), .HALT_INSTR(32'hFFFF_FFFF)) dut8 (
    .i_clock(clk),
    .i_reset(rst),
    .bus    (bus8.master)
  );

  instr_loader #(.MEM_SIZE(8), .INSTMEM_SIZE(4), .INST_SIZE(32), .HALT_INSTR(32'hFFFF_FFFF)) dut4 (
    .i_clock(clk),
    .i_reset(rst),
    .bus    (bus4.master)
  );

  // Count write pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus8.o_write_en === 1'b1) wr8++;
    if (bus4.o_write_en === 1'b1) wr4++;
  end

  typedef struct {
    logic       start;
    logic [7:0] data;
    logic [7:0] addr;
    logic       done;
  } vec_t;

  vec_t       vecs [20];
  logic [7:0] bytes_tbl [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;

    // Basic load (0..7) followed by a non-aligned 0xFF load (8..19).
    bytes_tbl = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                  8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00,
                  8'hFF, 8'hFF, 8'hFF, 8'hFF};
    for (int i = 0; i < 20; i++) begin
      vecs[i].start = (i == 0) || (i == 8);
      vecs[i].data  = bytes_tbl[i];
      vecs[i].addr  = (i < 8) ? 8'(i) : 8'(i - 8);
      vecs[i].done  = (i == 7) || (i == 19);
    end

    // Reset then idle.
    do_reset();
    chk("rst_pc_reset", 32'(bus8.o_pc_reset), 32'd1);
    chk("rst_write_en", 32'(bus8.o_write_en), 32'd0);
    chk("rst_done",     32'(bus8.o_done), 32'd0);
    chk("rst_addr",     32'(bus8.o_write_addr), 32'd0);
    chk("rst_data",     32'(bus8.o_write_data), 32'd0);
    chk("rst_loading",  32'(bus8.o_loading), 32'd0);
    chk("rst_overflow", 32'(bus8.o_overflow), 32'd0);
    chk("rst_memen",    32'(bus8.o_instrmem_en), 32'd0);
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h5A);
      tick();
      tick();
    end
    chk("idle_no_writes", 32'(wr8), 32'd0);
    chk("idle_loading",   32'(bus8.o_loading), 32'd0);

    // Table-driven loads.
    for (int i = 0; i < 20; i++) begin
      if (vecs[i].start) pulse_start();
      send_byte(vecs[i].data);
      chk($sformatf("we[%0d]", i),     32'(bus8.o_write_en), 32'd1);
      chk($sformatf("memen[%0d]", i),  32'(bus8.o_instrmem_en), 32'd1);
      chk($sformatf("addr[%0d]", i),   32'(bus8.o_write_addr), 32'(vecs[i].addr));
      chk($sformatf("data[%0d]", i),   32'(bus8.o_write_data), 32'(vecs[i].data));
      chk($sformatf("loading[%0d]", i), 32'(bus8.o_loading), 32'd1);
      tick();
      chk($sformatf("we_low[%0d]", i),  32'(bus8.o_write_en), 32'd0);
      chk($sformatf("done[%0d]", i),    32'(bus8.o_done), 32'(vecs[i].done));
      chk($sformatf("pcrst[%0d]", i),   32'(bus8.o_pc_reset), 32'(!vecs[i].done));
      tick();
      tick();
    end
    chk("total_writes", 32'(wr8), 32'd20);
    chk("done_memen",   32'(bus8.o_instrmem_en), 32'd1);
    chk("done_loading", 32'(bus8.o_loading), 32'd0);

    // Overflow on the 4-bit-address instance.
    do_reset();
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      send_byte(8'h11);
      chk($sformatf("ovf_we[%0d]", i),   32'(bus4.o_write_en), 32'd1);
      chk($sformatf("ovf_addr[%0d]", i), 32'(bus4.o_write_addr), 32'(i));
      tick();
      tick();
    end
    chk("ovf_flag",    32'(bus4.o_overflow), 32'd1);
    chk("ovf_pcrst",   32'(bus4.o_pc_reset), 32'd1);
    chk("ovf_done",    32'(bus4.o_done), 32'd0);
    chk("ovf_loading", 32'(bus4.o_loading), 32'd0);
    w = wr4;
    send_byte(8'h22);
    tick();
    chk("ovf_no_write", 32'(wr4), 32'(w));
    chk("ovf_hold",     32'(bus4.o_overflow), 32'd1);

    // HALT occupying the top word of the 4-bit-address instance.
    do_reset();
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      send_byte((i < 12) ? 8'h00 : 8'hFF);
      tick();
      tick();
    end
    chk("top_halt_addr", 32'(bus4.o_write_addr), 32'd15);
    chk("top_halt_done", 32'(bus4.o_done), 32'd1);
    chk("top_halt_ovf",  32'(bus4.o_overflow), 32'd0);
    chk("top_halt_pc",   32'(bus4.o_pc_reset), 32'd0);

    // Reset in the middle of a load.
    do_reset();
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h33);
      tick();
    end
    rst = 1'b1;
    tick();
    chk("midrst_addr",    32'(bus8.o_write_addr), 32'd0);
    chk("midrst_loading", 32'(bus8.o_loading), 32'd0);
    chk("midrst_pcrst",   32'(bus8.o_pc_reset), 32'd1);
    rst = 1'b0;
    tick();
    w = wr8;
    send_byte(8'h44);
    tick();
    chk("midrst_no_write", 32'(wr8), 32'(w));

    // Restart after a completed load.
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      send_byte((i < 4) ? 8'h00 : 8'hFF);
      tick();
    end
    chk("rs_done", 32'(bus8.o_done), 32'd1);
    pulse_start();
    chk("rs_done_clr", 32'(bus8.o_done), 32'd0);
    chk("rs_loading",  32'(bus8.o_loading), 32'd1);
    chk("rs_pcrst",    32'(bus8.o_pc_reset), 32'd1);
    send_byte(8'hAB);
    chk("rs_addr", 32'(bus8.o_write_addr), 32'd0);
    chk("rs_data", 32'(bus8.o_write_data), 32'hAB);
    chk("rs_we",   32'(bus8.o_write_en), 32'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Program-loading stage directly upstream of the instruction-fetch stage.
- Receives a byte stream from the UART receiver and writes it byte-by-byte into instruction memory through the fetch stage's write port (write enable, write data, write address, memory enable).
- Holds the PC in reset while loading.
- Detects the HALT word, then releases the PC so fetch starts at address 0.

Parameters:
- MEM_SIZE, 8: instruction-memory data width (one byte per write).
- INSTMEM_SIZE, 8: instruction-memory byte-address width.
- INST_SIZE, 32: instruction width; 4 bytes per instruction.
- HALT_INSTR, 32'hFFFFFFFF: end-of-program marker word.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle request to begin or restart a load.
- i_rx_data  in  8  byte from the UART receiver.
- i_rx_done  in  1  one-cycle strobe; i_rx_data is valid.
- o_write_en  out  1  instruction-memory write enable.
- o_instrmem_en  out  1  instruction-memory enable.
- o_write_data  out  MEM_SIZE  byte to write.
- o_write_addr  out  INSTMEM_SIZE  byte address to write.
- o_pc_reset  out  1  holds the fetch-stage PC in reset.
- o_loading  out  1  high while a load is in progress.
- o_done  out  1  HALT received; program loaded.
- o_overflow  out  1  memory filled with no HALT received.

Behaviour:
- Clock and reset: one clock, i_clock. Reset is synchronous and active-high on i_reset, sampled on the rising edge.
- Reset values:
  - state = IDLE.
  - Address counter = 0; byte index = 0; word shift register = 0.
  - o_write_en = 0, o_instrmem_en = 0, o_write_data = 0, o_write_addr = 0.
  - o_pc_reset = 1, o_loading = 0, o_done = 0, o_overflow = 0.
- All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.
- States:
  - IDLE: i_start -> clear counters -> WAIT_BYTE. i_rx_done is ignored.
  - WAIT_BYTE: on i_rx_done:
    - latch i_rx_data into o_write_data;
    - set o_write_addr = address counter;
    - shift the byte into the word register (first byte received = MSB, big-endian);
    - go to WRITE.
  - WRITE (exactly one cycle, write latency = 1 cycle after the strobe):
    - o_write_en = 1 and o_instrmem_en = 1.
    - Address counter +1; byte index +1 mod 4.
    - Next state, in priority order:
      - byte index was 3 and assembled word == HALT_INSTR -> DONE. The HALT word is itself stored.
      - address counter was 2^INSTMEM_SIZE-1 -> ERROR.
      - otherwise -> WAIT_BYTE.
  - DONE: o_done = 1, o_pc_reset = 0, o_instrmem_en = 1 (fetch reads), o_write_en = 0.
  - ERROR: o_overflow = 1, o_pc_reset = 1, no further writes.
- o_loading = 1 in WAIT_BYTE and WRITE only.
- o_pc_reset = 1 in every state except DONE.
- i_start in DONE or ERROR restarts a load: clear o_done and o_overflow, address 0, byte index 0 -> WAIT_BYTE.
- i_start during WAIT_BYTE or WRITE is ignored.
- i_rx_done arriving in WRITE is dropped. The UART byte period is much longer than one cycle, so this is legal by construction.
- HALT is checked only on 4-byte-aligned word boundaries; 0xFF bytes inside a non-HALT word do not terminate the load.
- The address counter never wraps silently: the last write goes to the top address, then ERROR, unless that final word completes HALT (HALT takes priority).
- Reset asserted mid-load aborts immediately to the reset values. Memory contents already written are left as-is.

Decomposition:
- Shared pipeline package holds:
  - state encoding localparams: IDLE=0, WAIT_BYTE=1, WRITE=2, DONE=3, ERROR=4 (3 bits);
  - the HALT_INSTR constant, shared with the decode and debug units.
- One sub-module: word_assembler. It is the 4-byte shift register with the byte index, and outputs the assembled word and a word_complete flag. It is reused by the debug unit's transmit path.

Test Plan:
- Reset then idle: i_reset=1 for 2 cycles -> o_pc_reset=1, o_write_en=0, o_done=0, o_write_addr=0. Then i_rx_done pulses with i_start=0 -> no writes.
- Basic load: i_start, then bytes 20 08 00 05 followed by FF FF FF FF -> eight single-cycle o_write_en pulses at addresses 0..7, each 1 cycle after its strobe, with matching data. o_done=1 and o_pc_reset=0 the cycle after the write to address 7.
- Non-aligned 0xFF: bytes 00 FF FF FF, FF 00 00 00, then HALT -> no early termination; o_done only after address 11.
- Overflow: INSTMEM_SIZE=4, 16 non-HALT bytes -> writes at 0..15, then o_overflow=1, o_pc_reset=1; a 17th strobe causes no write.
- HALT filling the top word: INSTMEM_SIZE=4, 12 bytes of 00 then FF×4 -> o_done=1 and o_overflow=0.
- Reset and restart: i_reset after byte 3 -> o_write_addr=0 and o_loading=0. After a completed load, i_start -> o_done drops, the next byte is written at address 0.
